mem_port_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for one shared 32-bit memory port; up to four requesters (e.g. IF, MEM, DMA, debug).
- Drives the 2-bit select of the 4:1 32-bit operand mux in front of the memory: address/wdata of the granted requester reach the port.
- Holds each grant for a fixed memory latency, pulses a per-requester done, then rotates priority.

---
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter/sequencer for one shared 32-bit memory port.
// Four requesters compete. The winner owns the port for MEM_LAT cycles and gets a
// one-cycle done pulse in its last cycle. Priority then rotates to the requester
// after the winner, and one idle cycle always separates consecutive grants.
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       mem_en,
    output logic [3:0] done,
    output logic       busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Counter load value on grant entry. Zero means a single-cycle transaction.
    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] sel_q, sel_d;
    logic       mem_en_q, mem_en_d;
    logic [3:0] done_q, done_d;
    logic       busy_q, busy_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] cnt_q, cnt_d;

    logic [3:0] req_rot;
    logic [1:0] win_off;
    logic [1:0] win_idx;
    logic       win_vld;
    logic [3:0] win_onehot;

    // Rotate the request vector so bit 0 is the current highest-priority requester.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rot
            assign req_rot[gi] = req[ptr_q + 2'(gi)];
        end
    endgenerate

    // Fixed-priority pick on the rotated view, then map the offset back to an index.
    always_comb begin
        win_off = 2'd0;
        if (req_rot[0])      win_off = 2'd0;
        else if (req_rot[1]) win_off = 2'd1;
        else if (req_rot[2]) win_off = 2'd2;
        else                 win_off = 2'd3;
        win_vld    = |req_rot;
        win_idx    = ptr_q + win_off;
        win_onehot = 4'b0001 << win_idx;
    end

    // Next-state and next-output computation. Outputs are precomputed so that
    // they change together with the state on the clock edge.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        sel_d    = sel_q;
        mem_en_d = mem_en_q;
        busy_d   = busy_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        done_d   = 4'b0000;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    state_d  = ST_GRANT;
                    grant_d  = win_onehot;
                    sel_d    = win_idx;
                    mem_en_d = 1'b1;
                    busy_d   = 1'b1;
                    cnt_d    = CNT_INIT;
                    // A single-cycle transaction completes in its first grant cycle.
                    if (CNT_INIT == 4'd0) begin
                        done_d = win_onehot;
                    end
                end
            end
            ST_GRANT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                    // The cycle in which cnt reaches zero is the final grant cycle.
                    if (cnt_q == 4'd1) begin
                        done_d = grant_q;
                    end
                end else begin
                    // Release the port; sel keeps the last winner while idle.
                    state_d  = ST_IDLE;
                    grant_d  = 4'b0000;
                    mem_en_d = 1'b0;
                    busy_d   = 1'b0;
                    ptr_d    = sel_q + 2'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register. Reset abandons any transaction in flight without a done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= 4'b0000;
            sel_q    <= 2'd0;
            mem_en_q <= 1'b0;
            done_q   <= 4'b0000;
            busy_q   <= 1'b0;
            ptr_q    <= 2'd0;
            cnt_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            sel_q    <= sel_d;
            mem_en_q <= mem_en_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign grant  = grant_q;
    assign sel    = sel_q;
    assign mem_en = mem_en_q;
    assign done   = done_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. Three instances with MEM_LAT = 2, 1 and 3 share one
// request/reset stream. Each instance has a transaction-level model that pushes
// expected transactions (winner, start edge, length, done) into its queue, and a
// monitor that rebuilds transactions from the DUT outputs and compares.
module tb_mem_port_arbiter;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req   = 4'b0000;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int w;
        int start;
        int len;
        bit has_done;
    } exp_t;

    always #5 clk = ~clk;

    // Edge counter: after the k-th rising edge cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input int lat, input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL lat=%0d %s: got %0d, expected %0d (cycle %0d)", lat, name, act, exp, cyc);
        end
    endtask

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_inst
            localparam int LAT = (gi == 0) ? 2 : ((gi == 1) ? 1 : 3);

            logic [3:0] grant;
            logic [1:0] sel;
            logic       mem_en;
            logic [3:0] done;
            logic       busy;

            exp_t exp_q[$];

            mem_port_arbiter #(.MEM_LAT(LAT)) u_dut (
                .clk    (clk),
                .rst_n  (rst_n),
                .req    (req),
                .grant  (grant),
                .sel    (sel),
                .mem_en (mem_en),
                .done   (done),
                .busy   (busy)
            );

            // Reference model: the port is free at edge free_at; a transaction won at
            // edge e occupies edges e..e+LAT-1 and the port is free again at e+LAT+1.
            initial begin : model
                int  e, ptr, free_at, st, w, k;
                bit  active, found;
                e = 0; ptr = 0; free_at = 0; st = 0; w = 0; active = 0;
                forever begin
                    @(posedge clk);
                    e++;
                    if (active && e == st + LAT) begin
                        exp_q.push_back('{w, st, LAT, 1'b1});
                        active = 0;
                    end
                    if (!rst_n) begin
                        if (active) begin
                            exp_q.push_back('{w, st, e - st, 1'b0});
                            active = 0;
                        end
                        ptr     = 0;
                        free_at = e + 1;
                    end else if (!active && e >= free_at && req != 4'b0000) begin
                        found = 0;
                        for (k = 0; k < 4; k++) begin
                            if (!found && (((int'(req) >> ((ptr + k) % 4)) & 1) == 1)) begin
                                w     = (ptr + k) % 4;
                                found = 1;
                            end
                        end
                        st      = e;
                        active  = 1;
                        ptr     = (w + 1) % 4;
                        free_at = e + LAT + 1;
                    end
                end
            end

            // Monitor: per-cycle invariants plus transaction reconstruction.
            initial begin : monitor
                bit   in_run, rst_prev;
                int   run_start, run_len, done_at, run_g, run_s;
                exp_t ex;
                in_run = 0; rst_prev = 1; run_start = 0; run_len = 0;
                done_at = -1; run_g = 0; run_s = 0;
                forever begin
                    @(negedge clk);
                    if (!rst_prev) begin
                        check(LAT, "reset_outputs", int'({grant, sel, mem_en, done, busy}), 0);
                    end
                    check(LAT, "mem_en_vs_grant", int'(mem_en), int'(|grant));
                    check(LAT, "busy_vs_mem_en", int'(busy), int'(mem_en));
                    check(LAT, "grant_onehot0", int'($onehot0(grant)), 1);
                    check(LAT, "done_within_grant", int'(done & ~grant), 0);
                    if (grant != 4'b0000) begin
                        if (!in_run) begin
                            in_run    = 1;
                            run_start = cyc;
                            run_g     = int'(grant);
                            run_s     = int'(sel);
                            run_len   = 0;
                            done_at   = -1;
                        end
                        check(LAT, "grant_held", int'(grant), run_g);
                        check(LAT, "sel_held", int'(sel), run_s);
                        check(LAT, "sel_matches_grant", int'(grant), 1 << int'(sel));
                        if (done != 4'b0000) begin
                            check(LAT, "done_once", done_at, -1);
                            check(LAT, "done_bit", int'(done), int'(grant));
                            done_at = run_len;
                        end
                        run_len++;
                    end else if (in_run) begin
                        in_run = 0;
                        if (exp_q.size() == 0) begin
                            check(LAT, "unexpected_grant", run_g, 0);
                        end else begin
                            ex = exp_q.pop_front();
                            $display("lat=%0d txn: grant=%b start=%0d len=%0d done_at=%0d (exp w=%0d start=%0d len=%0d done=%0b)",
                                     LAT, run_g[3:0], run_start, run_len, done_at, ex.w, ex.start, ex.len, ex.has_done);
                            check(LAT, "txn_winner", run_g, 1 << ex.w);
                            check(LAT, "txn_start", run_start, ex.start);
                            check(LAT, "txn_length", run_len, ex.len);
                            check(LAT, "txn_done_pos", done_at, ex.has_done ? ex.len - 1 : -1);
                        end
                    end
                    rst_prev = rst_n;
                end
            end
        end
    endgenerate

    // Apply new inputs shortly after a rising edge; they are sampled on the next one.
    task automatic step(input logic [3:0] r, input logic rn);
        @(posedge clk);
        #2;
        req   = r;
        rst_n = rn;
    endtask

    task automatic hold(input logic [3:0] r, input int n);
        for (int i = 0; i < n; i++) step(r, 1'b1);
    endtask

    initial begin : stimulus
        logic [3:0] r;
        logic       rn;
        // Reset with idle requesters
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        hold(4'b0000, 3);
        // Single requester 2, then everyone
        hold(4'b0100, 6);
        hold(4'b0000, 4);
        hold(4'b1111, 16);
        hold(4'b0000, 5);
        // Serve requester 2 so the pointer sits at 3, then requesters 0 and 1 contend
        hold(4'b0100, 2);
        hold(4'b0000, 5);
        hold(4'b0011, 12);
        hold(4'b0000, 5);
        // Single-cycle pulse from requester 3
        hold(4'b1000, 1);
        hold(4'b0000, 6);
        // Requester 1 drops its request right after being granted
        hold(4'b0010, 1);
        hold(4'b0000, 6);
        // Reset in the second grant cycle, then a normal request
        hold(4'b0100, 1);
        hold(4'b0000, 1);
        step(4'b0000, 1'b0);
        hold(4'b0001, 4);
        hold(4'b0000, 5);
        // Random phase: slowly varying requests with occasional resets
        r = 4'b0000;
        for (int i = 0; i < 500; i++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(3) == 0) r[b] = ~r[b];
            end
            rn = ($urandom_range(49) != 0);
            step(r, rn);
        end
        // Drain and confirm every predicted transaction was observed
        hold(4'b0000, 25);
        @(negedge clk);
        check(2, "queue_drained", g_inst[0].exp_q.size(), 0);
        check(1, "queue_drained", g_inst[1].exp_q.size(), 0);
        check(3, "queue_drained", g_inst[2].exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
